accum_window_sched: RTL and testbench

Windowed-average scheduler that time-shares one 4-bit sample accumulator between `N_CH` requesting channels. A round-robin arbiter grants one channel at a time. The granted channel's samples are summed over a fixed window of `WIN` enabled cycles. The block reports the scaled sum (top 5 bits of the accumulator) tagged with the channel index. It sits between the sample sources and the measurement/readout logic and replaces free-running per-channel accumulators plus window-reset counters.

---
 rtl/accum_pkg.sv | 22 ++
 rtl/accum_window_sched_if.sv | 37 +++
 rtl/accum_window_sched_rr_arbiter.sv | 41 ++++
 rtl/accum_window_sched.sv | 127 ++++++++++++
 tb/tb_accum_window_sched.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared definitions for the windowed-average scheduler.
//   DATA_W : width of one channel sample
//   RES_W  : width of the reported (scaled) window sum
//   state_e: FSM state encoding
//   acc_w(): accumulator width for a given log2 window length
package accum_pkg;

  localparam int DATA_W = 4;
  localparam int RES_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Wide enough for 15 * 2**win_log2, so the window sum never overflows.
  function automatic int acc_w(input int win_log2);
    return DATA_W + win_log2;
  endfunction

endpackage

// File: rtl/accum_window_sched_if.sv
// Bus between the sample sources / readout logic and accum_window_sched.
//   req          : per-channel request, level-sensitive
//   data         : packed 4-bit samples, channel i at [4*i+3:4*i]
//   en           : sample enable
//   gnt          : one-hot grant, held for the whole window
//   busy         : window in progress or being reported
//   result       : scaled window sum
//   result_ch    : channel index of result
//   result_valid : one-cycle pulse when result/result_ch update
// master = source/readout side, slave = scheduler.
interface accum_window_sched_if #(
  parameter int N_CH = 4
);
  import accum_pkg::*;

  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        req;
  logic [DATA_W*N_CH-1:0] data;
  logic                   en;
  logic [N_CH-1:0]        gnt;
  logic                   busy;
  logic [RES_W-1:0]       result;
  logic [CH_W-1:0]        result_ch;
  logic                   result_valid;

  modport master (
    output req, data, en,
    input  gnt, busy, result, result_ch, result_valid
  );

  modport slave (
    input  req, data, en,
    output gnt, busy, result, result_ch, result_valid
  );

endinterface

// File: rtl/accum_window_sched_rr_arbiter.sv
// Combinational round-robin picker.
//   req      : request vector
//   last     : index granted most recently
//   pick     : one-hot winner (all zero when no request)
//   pick_idx : binary index of the winner
// The search starts one past last and wraps, so the last winner has
// the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] pick_idx
);

  localparam int IDX_W = $clog2(N);

  int               pos;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    pos      = 0;
    cand     = '0;
    for (int i = 1; i <= N; i++) begin
      pos = int'(last) + i;
      if (pos >= N) pos = pos - N;
      cand = IDX_W'(pos);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/accum_window_sched.sv
// Windowed-average scheduler: one shared accumulator time-shared
// between N_CH channels under round-robin arbitration.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of accum_window_sched_if (req/data/en in,
//              gnt/busy/result/result_ch/result_valid out)
// Parameters: N_CH channels (2..8), window of 2**WIN_LOG2 enabled samples.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no grant; arbitrate on req, grant and clear on any request
// ACCUM | sum granted channel on en cycles until WIN samples taken
// DONE  | result_valid pulse, grant released, back to IDLE
module accum_window_sched
  import accum_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIN_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  accum_window_sched_if.slave  bus
);

  localparam int ACC_W = acc_w(WIN_LOG2);
  localparam int CH_W  = $clog2(N_CH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ACCUM = ACCUM;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]          state_q, state_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     gnt_idx_q, gnt_idx_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [CH_W-1:0]     result_ch_q, result_ch_d;

  logic [N_CH-1:0]     pick;
  logic [CH_W-1:0]     pick_idx;
  logic [DATA_W-1:0]   sample;
  logic [ACC_W-1:0]    acc_sum;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req      (bus.req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  assign sample  = bus.data[DATA_W*gnt_idx_q +: DATA_W];
  assign acc_sum = acc_q + ACC_W'(sample);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          gnt_d     = pick;
          gnt_idx_d = pick_idx;
          last_d    = pick_idx;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.en) begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          // Terminal count: the final sample is folded into the result.
          if (cnt_q == '1) begin
            result_d    = acc_sum[ACC_W-1 -: RES_W];
            result_ch_d = gnt_idx_q;
            gnt_d       = '0;
            state_d     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      last_q      <= CH_W'(N_CH - 1);
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.result       = result_q;
  assign bus.result_ch    = result_ch_q;
  assign bus.result_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_accum_window_sched.sv
// Bench for accum_window_sched: directed windows with random sample data,
// checked against a transaction-level model (round-robin order, window sum
// of enabled samples, scaled by the window length).
module tb_accum_window_sched;

  localparam int N_CH     = 4;
  localparam int WIN_LOG2 = 5;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int SHIFT    = WIN_LOG2 - 1;

  localparam int DM_RAND = 0;
  localparam int DM_15   = 1;
  localparam int DM_ONE  = 2;
  localparam int DM_ALT  = 3;

  localparam int EN_ON    = 0;
  localparam int EN_RAND  = 1;
  localparam int EN_PAUSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  accum_window_sched_if #(.N_CH(N_CH)) bus ();

  accum_window_sched #(.N_CH(N_CH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_last = N_CH - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rr_next(input int last, input logic [N_CH-1:0] r);
    int c;
    for (int i = 1; i <= N_CH; i++) begin
      c = (last + i) % N_CH;
      if ((r & (N_CH'(1) << c)) != '0) return c;
    end
    return -1;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_valid"}, 32'(bus.result_valid), 0);
  endtask

  // Entered at a negedge with the DUT in IDLE; returns at the negedge of
  // the following IDLE cycle (or just after a mid-window reset).
  task automatic do_window(input logic [N_CH-1:0] reqv, input int dmode, input int emode,
                           input int drop_at, input int rst_at,
                           output int res, output int rch, output int valid_cyc,
                           output int gnt_cycles);
    int exp_ch, sum, n, paused, iters, exp_res;
    logic e;
    logic [4*N_CH-1:0] dv;
    res = -1; rch = -1; valid_cyc = -1; gnt_cycles = 0;
    bus.req = reqv;
    exp_ch = rr_next(m_last, reqv);
    @(negedge clk);
    chk("gnt_first", 32'(bus.gnt), 32'(1 << exp_ch));
    chk("busy_accum", 32'(bus.busy), 1);
    m_last = exp_ch;
    sum = 0; n = 0; paused = 0; iters = 0;
    while (n < WIN) begin
      if (iters > 4 * WIN) begin
        chk("window_timeout", 32'(n), 32'(WIN));
        return;
      end
      iters++;
      chk("gnt_hold", 32'(bus.gnt), 32'(1 << exp_ch));
      chk("valid_low", 32'(bus.result_valid), 0);
      gnt_cycles++;
      if (n == rst_at) begin
        rst = 1'b1;
        bus.req = '0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_result_ch", 32'(bus.result_ch), 0);
        chk("rst_valid", 32'(bus.result_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        m_last = N_CH - 1;
        return;
      end
      for (int c = 0; c < N_CH; c++) dv[4*c +: 4] = 4'($urandom_range(0, 15));
      case (dmode)
        DM_15:   dv[4*exp_ch +: 4] = 4'd15;
        DM_ONE:  for (int c = 0; c < N_CH; c++) dv[4*c +: 4] = 4'd1;
        DM_ALT:  dv[4*exp_ch +: 4] = (n % 2 == 1) ? 4'd15 : 4'd0;
        default: ;
      endcase
      if (emode == EN_RAND) e = ($urandom_range(0, 3) != 0);
      else if (emode == EN_PAUSE && n == 8 && paused < 10) e = 1'b0;
      else e = 1'b1;
      if (!e) paused++;
      if (n == drop_at) bus.req = '0;
      bus.data = dv;
      bus.en = e;
      if (e) begin
        sum += int'(dv[4*exp_ch +: 4]);
        n++;
      end
      @(negedge clk);
    end
    exp_res = sum >> SHIFT;
    chk("done_valid", 32'(bus.result_valid), 1);
    chk("done_result", 32'(bus.result), 32'(exp_res));
    chk("done_result_ch", 32'(bus.result_ch), 32'(exp_ch));
    chk("done_gnt", 32'(bus.gnt), 0);
    chk("done_busy", 32'(bus.busy), 1);
    res = int'(bus.result);
    rch = int'(bus.result_ch);
    valid_cyc = cyc;
    bus.en = 1'($urandom_range(0, 1));
    bus.data = (4*N_CH)'($urandom);
    @(negedge clk);
    chk_idle_outputs("post_idle");
    chk("result_hold", 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    int res, rch, vc, gc, prev_vc;
    int exp_order [5];
    logic [N_CH-1:0] rq;
    exp_order = '{0, 1, 2, 3, 0};
    bus.req = '0;
    bus.data = '0;
    bus.en = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_result", 32'(bus.result), 0);
    chk("reset_result_ch", 32'(bus.result_ch), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // All channels requesting, data 1: round-robin order and 34-cycle spacing.
    prev_vc = -1;
    for (int w = 0; w < 5; w++) begin
      do_window('1, DM_ONE, EN_ON, -1, -1, res, rch, vc, gc);
      chk("rr_result", 32'(res), 2);
      chk("rr_order", 32'(rch), 32'(exp_order[w]));
      if (w > 0) chk("rr_spacing", 32'(vc - prev_vc), 32'(WIN + 2));
      prev_vc = vc;
    end

    // Single channel at full scale.
    do_window(4'b0001, DM_15, EN_ON, -1, -1, res, rch, vc, gc);
    chk("full_result", 32'(res), 30);
    chk("full_gnt_cycles", 32'(gc), 32'(WIN));

    // Alternating 0/15 on channel 2.
    do_window(4'b0100, DM_ALT, EN_ON, -1, -1, res, rch, vc, gc);
    chk("alt_result", 32'(res), 15);
    chk("alt_ch", 32'(rch), 2);
    chk("alt_gnt_cycles", 32'(gc), 32'(WIN));

    // Ten-cycle enable pause after sample 8.
    do_window(4'b0001, DM_15, EN_PAUSE, -1, -1, res, rch, vc, gc);
    chk("pause_result", 32'(res), 30);
    chk("pause_gnt_cycles", 32'(gc), 32'(WIN + 10));

    // Request dropped mid-window: window completes, no regrant afterwards.
    do_window(4'b0010, DM_RAND, EN_ON, 5, -1, res, rch, vc, gc);
    chk("drop_ch", 32'(rch), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle_outputs("drop_idle");
    end

    // Random requests, data and enables.
    for (int w = 0; w < 6; w++) begin
      rq = N_CH'($urandom_range(1, (1 << N_CH) - 1));
      do_window(rq, DM_RAND, EN_RAND, -1, -1, res, rch, vc, gc);
    end

    // Reset at sample 20 discards the window; channel 0 wins afterwards.
    do_window(4'b1000, DM_15, EN_ON, -1, 20, res, rch, vc, gc);
    for (int i = 0; i < WIN + 4; i++) begin
      @(negedge clk);
      chk("rst_no_valid", 32'(bus.result_valid), 0);
    end
    do_window('1, DM_RAND, EN_ON, -1, -1, res, rch, vc, gc);
    chk("rst_first_ch", 32'(rch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
